// File: rtl/simon_sequencer.sv
// -----------------------------------------------------------------------------
// simon_sequencer
//   Memory-game sequencer. Grows a random colour sequence one entry per round,
//   replays it with a blank gap between colours, then checks the player's
//   entries (with an optional per-entry timeout). Keeps the score of the
//   current/last game and the best score since reset, and selects a timer
//   tempo that speeds up as the sequence grows.
//
// Ports
//   CLK, RST_N    clock, asynchronous active-low reset
//   START_GAME    start request, only honoured while idle
//   IN, IN_VALID  player colour and its one-cycle strobe
//   RAND          random colour, sampled when a new entry is appended
//   TIMER_PULSE   external timer period elapsed (one cycle)
//   TIMER_GO      restart the external timer (one cycle)
//   TEMPO         timer period select, 0 = slowest
//   OUT, OUT_ENA  colour to display and display enable
//   WIN, LOSE     result of the last game (levels)
//   HS            one-cycle pulse when a new high score is recorded
//   SCORE         completed rounds in the current/last game
//   HIGH_SCORE    best SCORE since reset
// -----------------------------------------------------------------------------
module simon_sequencer #(
    parameter int CW         = 2,
    parameter int DEPTH      = 32,
    parameter int TIMEOUT    = 8,
    parameter int SPEED_STEP = 8
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       START_GAME,
    input  logic [CW-1:0]              IN,
    input  logic                       IN_VALID,
    input  logic [CW-1:0]              RAND,
    input  logic                       TIMER_PULSE,
    output logic                       TIMER_GO,
    output logic [1:0]                 TEMPO,
    output logic [CW-1:0]              OUT,
    output logic                       OUT_ENA,
    output logic                       WIN,
    output logic                       LOSE,
    output logic                       HS,
    output logic [$clog2(DEPTH+1)-1:0] SCORE,
    output logic [$clog2(DEPTH+1)-1:0] HIGH_SCORE
);

    localparam int SW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT+2);
    // Divisor that is safe to elaborate even when the tempo feature is off.
    localparam int SS = (SPEED_STEP == 0) ? 1 : SPEED_STEP;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT-1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADD, S_SHOW, S_GAP, S_INPUT, S_WIN, S_LOSE, S_END
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   cnt_q;
    logic [IW-1:0]   i_q;
    logic [TW-1:0]   tmo_q;
    logic            go_q;
    logic [1:0]      tempo_q;
    logic [CW-1:0]   out_q;
    logic            ena_q;
    logic            win_q;
    logic            lose_q;
    logic            hs_q;
    logic [SW-1:0]   score_q;
    logic [SW-1:0]   high_q;
    logic [CW-1:0]   stack_q [DEPTH];

    logic [CW-1:0]   cur_colour;
    logic            last_entry;

    assign cur_colour = stack_q[i_q];
    assign last_entry = (SW'(i_q) + SW'(1)) == cnt_q;

    function automatic logic [1:0] tempo_of(input logic [SW-1:0] c);
        int q;
        q = int'(c) / SS;
        if (SPEED_STEP == 0) return 2'd0;
        return (q >= 3) ? 2'd3 : q[1:0];
    endfunction

    // Sequence storage needs no reset; only entries below cnt are ever read.
    always_ff @(posedge CLK) begin
        if (state_q == S_ADD && cnt_q != SW'(DEPTH))
            stack_q[cnt_q[IW-1:0]] <= RAND;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            i_q     <= '0;
            tmo_q   <= '0;
            go_q    <= 1'b0;
            tempo_q <= '0;
            out_q   <= '1;
            ena_q   <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            hs_q    <= 1'b0;
            score_q <= '0;
            high_q  <= '0;
        end else begin
            go_q    <= 1'b0;
            hs_q    <= 1'b0;
            tempo_q <= tempo_of(cnt_q);
            case (state_q)
                S_IDLE: begin
                    ena_q <= 1'b0;
                    if (START_GAME) begin
                        win_q   <= 1'b0;
                        lose_q  <= 1'b0;
                        score_q <= '0;
                        cnt_q   <= '0;
                        state_q <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (cnt_q == SW'(DEPTH)) begin
                        state_q <= S_WIN;
                    end else begin
                        cnt_q   <= cnt_q + SW'(1);
                        i_q     <= '0;
                        state_q <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    // The display is always dark on entry, so a low enable
                    // marks the first cycle: light the colour and start the
                    // timer. A pulse in that cycle belongs to the old period.
                    if (!ena_q) begin
                        out_q <= cur_colour;
                        ena_q <= 1'b1;
                        go_q  <= 1'b1;
                    end else if (TIMER_PULSE) begin
                        ena_q   <= 1'b0;
                        go_q    <= 1'b1;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (TIMER_PULSE) begin
                        if (last_entry) begin
                            i_q     <= '0;
                            tmo_q   <= '0;
                            go_q    <= 1'b1;
                            state_q <= S_INPUT;
                        end else begin
                            i_q     <= i_q + IW'(1);
                            state_q <= S_SHOW;
                        end
                    end
                end
                S_INPUT: begin
                    // A player entry takes priority over a coincident tick.
                    if (IN_VALID) begin
                        if (IN == cur_colour) begin
                            tmo_q <= '0;
                            go_q  <= 1'b1;
                            if (last_entry) begin
                                score_q <= cnt_q;
                                state_q <= S_ADD;
                            end else begin
                                i_q <= i_q + IW'(1);
                            end
                        end else begin
                            state_q <= S_LOSE;
                        end
                    end else if (TIMER_PULSE && (TIMEOUT != 0)) begin
                        if (tmo_q == TMO_LAST) begin
                            state_q <= S_LOSE;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                            go_q  <= 1'b1;
                        end
                    end
                end
                S_WIN: begin
                    win_q   <= 1'b1;
                    state_q <= S_END;
                end
                S_LOSE: begin
                    lose_q  <= 1'b1;
                    ena_q   <= 1'b0;
                    state_q <= S_END;
                end
                S_END: begin
                    if (score_q > high_q) begin
                        high_q <= score_q;
                        hs_q   <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign TIMER_GO   = go_q;
    assign TEMPO      = tempo_q;
    assign OUT        = out_q;
    assign OUT_ENA    = ena_q;
    assign WIN        = win_q;
    assign LOSE       = lose_q;
    assign HS         = hs_q;
    assign SCORE      = score_q;
    assign HIGH_SCORE = high_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// -----------------------------------------------------------------------------
// tb_simon_sequencer
//   Directed games against simon_sequencer (DEPTH=8, TIMEOUT=3, SPEED_STEP=2).
//   A small timer model answers TIMER_GO with a TIMER_PULSE a few cycles later.
//   The driver plays games and pushes the events it expects (colour shown with
//   tempo, score update, win, lose, high-score pulse) into a queue; a monitor
//   pops and compares whenever the DUT produces one of those events.
// -----------------------------------------------------------------------------
module tb_simon_sequencer;

    localparam int CW         = 2;
    localparam int DEPTH      = 8;
    localparam int TIMEOUT    = 3;
    localparam int SPEED_STEP = 2;
    localparam int SW         = $clog2(DEPTH+1);
    localparam int PER        = 4;

    localparam int K_SHOW  = 0;
    localparam int K_SCORE = 1;
    localparam int K_WIN   = 2;
    localparam int K_LOSE  = 3;
    localparam int K_HS    = 4;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          START_GAME = 1'b0;
    logic [CW-1:0] IN = '0;
    logic          IN_VALID = 1'b0;
    logic [CW-1:0] RAND = '0;
    logic          TIMER_PULSE = 1'b0;
    logic          TIMER_GO;
    logic [1:0]    TEMPO;
    logic [CW-1:0] OUT;
    logic          OUT_ENA;
    logic          WIN;
    logic          LOSE;
    logic          HS;
    logic [SW-1:0] SCORE;
    logic [SW-1:0] HIGH_SCORE;

    simon_sequencer #(
        .CW(CW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .SPEED_STEP(SPEED_STEP)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .START_GAME(START_GAME),
        .IN(IN), .IN_VALID(IN_VALID), .RAND(RAND), .TIMER_PULSE(TIMER_PULSE),
        .TIMER_GO(TIMER_GO), .TEMPO(TEMPO), .OUT(OUT), .OUT_ENA(OUT_ENA),
        .WIN(WIN), .LOSE(LOSE), .HS(HS), .SCORE(SCORE), .HIGH_SCORE(HIGH_SCORE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  seq[DEPTH];
    int  hi_model = 0;

    function automatic string kname(input int k);
        case (k)
            K_SHOW:  return "show";
            K_SCORE: return "score";
            K_WIN:   return "win";
            K_LOSE:  return "lose";
            default: return "hs";
        endcase
    endfunction

    function automatic int tempo_of(input int c);
        int s;
        s = c / SPEED_STEP;
        return (s > 3) ? 3 : s;
    endfunction

    task automatic push_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Round r shows seq[0..r-1], each at the tempo for a sequence of length r.
    task automatic push_show(input int r);
        for (int k = 0; k < r; k++) push_ev(K_SHOW, seq[k] * 4 + tempo_of(r));
    endtask

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting, got no event, expected one", name);
    endtask

    task automatic ev_check(input int kind, input int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got %s=%0d, expected no event", kname(kind), val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                errors++;
                $display("FAIL event: got %s=%0d, expected %s=%0d",
                         kname(kind), val, kname(e.kind), e.val);
            end
        end
    endtask

    // Timer model: a pulse follows each TIMER_GO after PER cycles.
    int cd = 0;
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (TIMER_GO) begin
                cd = PER;
                TIMER_PULSE = 1'b0;
            end else if (cd > 0) begin
                cd--;
                TIMER_PULSE = (cd == 0);
            end else begin
                TIMER_PULSE = 1'b0;
            end
        end
    end

    // Monitor: turns output changes into events and checks them in order.
    logic pe = 1'b0, pw = 1'b0, pl = 1'b0;
    int   ps = 0;
    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1) begin
                if (int'(SCORE) != ps && SCORE != '0) ev_check(K_SCORE, int'(SCORE));
                if (OUT_ENA && !pe) ev_check(K_SHOW, int'(OUT) * 4 + int'(TEMPO));
                if (WIN && !pw) ev_check(K_WIN, 1);
                if (LOSE && !pl) ev_check(K_LOSE, int'(OUT_ENA));
                if (HS) ev_check(K_HS, int'(HIGH_SCORE));
            end
            pe = OUT_ENA;
            pw = WIN;
            pl = LOSE;
            ps = int'(SCORE);
        end
    end

    task automatic check_reset(input string tag);
        check({tag, " TIMER_GO"}, int'(TIMER_GO), 0);
        check({tag, " TEMPO"}, int'(TEMPO), 0);
        check({tag, " OUT"}, int'(OUT), (1 << CW) - 1);
        check({tag, " OUT_ENA"}, int'(OUT_ENA), 0);
        check({tag, " WIN"}, int'(WIN), 0);
        check({tag, " LOSE"}, int'(LOSE), 0);
        check({tag, " HS"}, int'(HS), 0);
        check({tag, " SCORE"}, int'(SCORE), 0);
        check({tag, " HIGH_SCORE"}, int'(HIGH_SCORE), 0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic start_game();
        RAND = CW'(seq[0]);
        push_show(1);
        START_GAME = 1'b1;
        @(negedge CLK);
        START_GAME = 1'b0;
    endtask

    task automatic enter(input int col);
        IN = CW'(col);
        IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        @(negedge CLK);
    endtask

    // Return at the negedge where TIMER_PULSE is driven for the coming edge.
    task automatic wait_level(output bit ok);
        int n = 0;
        while (!TIMER_PULSE && n < 100) begin
            @(negedge CLK);
            n++;
        end
        ok = (n < 100);
        if (!ok) bound_fail("timer pulse");
    endtask

    // Let one timer pulse be consumed by the DUT.
    task automatic wait_pulse(output bit ok);
        wait_level(ok);
        if (ok) @(negedge CLK);
    endtask

    // Wait for r colours to go dark and the final gap to end.
    task automatic wait_input(input int r, output bit ok);
        int   falls = 0;
        int   n = 0;
        logic prev;
        prev = OUT_ENA;
        while (falls < r && n < 2000) begin
            @(negedge CLK);
            n++;
            if (prev && !OUT_ENA) falls++;
            prev = OUT_ENA;
        end
        while (!TIMER_PULSE && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        ok = (n < 2000);
        if (!ok) bound_fail("playback of round");
        else @(negedge CLK);
    endtask

    task automatic play_round(input int r, input int wrong_at, input bit late_first);
        bit ok;
        wait_input(r, ok);
        if (!ok) return;
        if (late_first) begin
            wait_pulse(ok);
            if (ok) wait_pulse(ok);
            if (ok) wait_level(ok);
            if (!ok) return;
        end
        for (int k = 0; k < r; k++) begin
            if (k == wrong_at) begin
                push_ev(K_LOSE, 0);
                if (r - 1 > hi_model) begin
                    push_ev(K_HS, r - 1);
                    hi_model = r - 1;
                end
                enter((seq[k] + 1) % (1 << CW));
                return;
            end
            if (k == r - 1) begin
                push_ev(K_SCORE, r);
                if (r < DEPTH) begin
                    RAND = CW'(seq[r]);
                    push_show(r + 1);
                end else begin
                    push_ev(K_WIN, 1);
                    if (DEPTH > hi_model) begin
                        push_ev(K_HS, DEPTH);
                        hi_model = DEPTH;
                    end
                end
            end
            enter(seq[k]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int n;

        // Reset
        tick(3);
        check_reset("reset");
        RST_N = 1'b1;
        tick(2);
        check_reset("after reset");

        // Game A: two rounds correct, wrong second entry in round 3
        seq = '{2, 1, 3, 0, 0, 0, 0, 0};
        start_game();
        play_round(1, -1, 1'b0);
        play_round(2, -1, 1'b0);
        play_round(3, 1, 1'b0);
        tick(4);
        check("A LOSE", int'(LOSE), 1);
        check("A WIN", int'(WIN), 0);
        check("A SCORE", int'(SCORE), 2);
        check("A HIGH_SCORE", int'(HIGH_SCORE), 2);
        check("A OUT_ENA", int'(OUT_ENA), 0);

        // Game B: entry timeout, with an input after the 2nd tick resetting it
        seq = '{1, 3, 0, 0, 0, 0, 0, 0};
        start_game();
        tick(1);
        check("B LOSE cleared", int'(LOSE), 0);
        check("B SCORE cleared", int'(SCORE), 0);
        play_round(1, -1, 1'b0);
        wait_input(2, ok);
        if (ok) begin
            push_ev(K_LOSE, 0);
            wait_pulse(ok);
            if (ok) wait_pulse(ok);
            check("B LOSE after 2 ticks", int'(LOSE), 0);
            enter(seq[0]);
            for (int p = 1; p <= 3 && ok; p++) begin
                wait_pulse(ok);
                tick(3);
                check($sformatf("B LOSE after tick %0d", p), int'(LOSE), (p == 3) ? 1 : 0);
            end
        end
        tick(3);
        check("B SCORE", int'(SCORE), 1);
        check("B HIGH_SCORE", int'(HIGH_SCORE), 2);

        // Game C: full win, round 2 first entry coincides with the 3rd tick
        seq = '{0, 3, 1, 2, 2, 0, 1, 3};
        start_game();
        play_round(1, -1, 1'b0);
        play_round(2, -1, 1'b1);
        check("C LOSE after coincident entry", int'(LOSE), 0);
        for (int r = 3; r <= DEPTH; r++) play_round(r, -1, 1'b0);
        tick(5);
        check("C WIN", int'(WIN), 1);
        check("C LOSE", int'(LOSE), 0);
        check("C OUT_ENA", int'(OUT_ENA), 0);
        check("C SCORE", int'(SCORE), DEPTH);
        check("C HIGH_SCORE", int'(HIGH_SCORE), DEPTH);

        // Game D: asynchronous reset while a colour is displayed
        seq = '{1, 0, 0, 0, 0, 0, 0, 0};
        start_game();
        n = 0;
        while (!OUT_ENA && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) bound_fail("D show");
        #2;
        RST_N = 1'b0;
        #1;
        check_reset("mid-show reset");
        @(negedge CLK);
        RST_N = 1'b1;
        hi_model = 0;
        tick(10);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending events: got %0d left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
